cfu_ram_arbiter: RTL
====================

CFU_RAM_ARBITER -- requirements
Module: cfu_ram_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requester ports (2..4).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the ack wait limit in clocks (1..255).
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_cyc, input, NUM_REQ, per-requester bus-cycle request.
REQ-006 The block SHALL have port req_stb, input, NUM_REQ, per-requester strobe.
REQ-007 The block SHALL have port req_we, input, NUM_REQ, per-requester write enable.
REQ-008 The block SHALL have port req_adr, input, 30*NUM_REQ, packed word addresses, requester i at [30*i+:30].
REQ-009 The block SHALL have port req_dat_mosi, input, 32*NUM_REQ, packed write data.
REQ-010 The block SHALL have port req_sel, input, 4*NUM_REQ, packed byte selects.
REQ-011 The block SHALL have port req_ack, output, NUM_REQ, per-requester acknowledge.
REQ-012 The block SHALL have port req_err, output, NUM_REQ, per-requester error.
REQ-013 The block SHALL have port req_dat_miso, output, 32, read data broadcast to all requesters.
REQ-014 The block SHALL have ports cfu_ram_adr (out, 30), cfu_ram_dat_mosi (out, 32), cfu_ram_sel (out, 4), cfu_ram_cyc, cfu_ram_stb, cfu_ram_we (out, 1 each), forming the shared Wishbone master.
REQ-015 The block SHALL have ports cfu_ram_cti (out, 3) and cfu_ram_bte (out, 2), tied to 0.
REQ-016 The block SHALL have ports cfu_ram_dat_miso (in, 32), cfu_ram_ack (in, 1) and cfu_ram_err (in, 1).
REQ-017 The block SHALL have port grant_id, output, 2, index of the current owner (debug).

Function
REQ-018 The FSM SHALL have two states, ARB_IDLE and ARB_BUSY, and SHALL update state on the rising edge of clk.
REQ-019 In ARB_IDLE with any req_cyc high, the block SHALL pick a winner round-robin starting at last_grant+1 mod NUM_REQ, register it into grant_id, and enter ARB_BUSY on the next clock.
REQ-020 In ARB_IDLE, all cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, req_ack and req_err SHALL be 0, so arbitration costs exactly one idle cycle.
REQ-021 In ARB_BUSY, cfu_ram_adr, dat_mosi, sel, we, cyc and stb SHALL combinationally follow the granted requester's inputs.
REQ-022 In ARB_BUSY, cfu_ram_ack and cfu_ram_err SHALL route only to req_ack[grant_id] and req_err[grant_id]; all other ack/err bits SHALL stay 0.
REQ-023 The owner SHALL keep the bus across multiple strobes while its req_cyc stays high (locked transfers).
REQ-024 When req_cyc[grant_id] falls, the FSM SHALL return to ARB_IDLE on that clock edge, and last_grant SHALL take the value of grant_id.
REQ-025 A requester whose cyc rises while another owns the bus SHALL wait without receiving ack or err.
REQ-026 If ack and err arrive in the same cycle, err SHALL win: req_ack SHALL be 0 and req_err SHALL be 1.
REQ-027 req_dat_miso SHALL equal cfu_ram_dat_miso unregistered.

Reset
REQ-028 On reset the block SHALL set state to ARB_IDLE, grant_id and last_grant to NUM_REQ-1 (so requester 0 wins first), and the timeout counter to 0.
REQ-029 During reset all bus outputs and all req_ack/req_err SHALL be 0.
REQ-030 Reset mid-transfer SHALL drop cfu_ram_cyc/stb immediately, and no ack SHALL be forwarded.

Configuration
REQ-031 With CFU_RAM_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL increment each ARB_BUSY cycle in which stb is high and ack and err are low, and SHALL clear otherwise.
REQ-032 When the counter reaches TIMEOUT_CYCLES, the block SHALL pulse req_err[grant_id] for one cycle, force cfu_ram_cyc/stb low for that cycle, clear the counter, and enter ARB_IDLE.
REQ-033 Without CFU_RAM_ARB_TIMEOUT_EN, the block SHALL have no counter and SHALL wait indefinitely for ack or err.

Structure
REQ-034 Package cfu_ram_pkg SHALL hold the arb_state_t enum, WB_ADR_W=30, WB_DAT_W=32 and WB_SEL_W=4.
REQ-035 The round-robin winner logic SHALL be sub-module rr_pick (inputs: request vector and last grant; output: winner index and a valid flag).

Verification
REQ-036 With only req 0 driving cyc/stb at adr 0x100 and ack given 2 cycles later with miso 0xDEADBEEF, req_ack[0] SHALL pulse once and req_dat_miso SHALL be 0xDEADBEEF.
REQ-037 With req 0 and req 1 raising cyc in the same cycle after reset, req 0 SHALL be granted first and req 1 after req 0 drops cyc plus one idle cycle.
REQ-038 With both requesters continuously requesting, grants SHALL alternate 0,1,0,1 across four transfers.
REQ-039 With req 1 owning and cfu_ram_err asserted together with ack, req_err[1]=1 and req_ack[1]=0.
REQ-040 With TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack, req_err pulses after 4 stb cycles, and the next requester SHALL then be granted.
REQ-041 Asserting reset during an active transfer SHALL immediately set cfu_ram_cyc=0 and grant_id=NUM_REQ-1.

Source files
------------

// File: rtl/cfu_ram_pkg.sv
// Shared types and Wishbone widths for the CFU RAM arbiter.
package cfu_ram_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int GRANT_W  = 2;
    localparam int TO_CNT_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Returns {err, ack}. An error in the same cycle as an ack suppresses the ack.
    function automatic logic [1:0] resolve_ack_err(input logic ack, input logic err);
        return {err, ack & ~err};
    endfunction

endpackage

// File: rtl/cfu_ram_arbiter_rr_pick.sv
// Round-robin winner selection: the search starts one past the last grant.
module rr_pick
    import cfu_ram_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] last_i,
    output logic [GRANT_W-1:0] win_o,
    output logic               valid_o
);

    // Scan farthest offset first so the nearest requester after last_i overwrites.
    always_comb begin
        win_o   = last_i;
        valid_o = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == ((int'(last_i) + k) % NUM_REQ)) && req_i[j]) begin
                    win_o   = GRANT_W'(j);
                    valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cfu_ram_arbiter.sv
// Round-robin arbiter sharing one Wishbone master among NUM_REQ requesters.
// Optional ack watchdog enabled by defining CFU_RAM_ARB_TIMEOUT_EN.
module cfu_ram_arbiter
    import cfu_ram_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_cyc,
    input  logic [NUM_REQ-1:0]           req_stb,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [WB_ADR_W*NUM_REQ-1:0]  req_adr,
    input  logic [WB_DAT_W*NUM_REQ-1:0]  req_dat_mosi,
    input  logic [WB_SEL_W*NUM_REQ-1:0]  req_sel,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           req_err,
    output logic [WB_DAT_W-1:0]          req_dat_miso,
    output logic [WB_ADR_W-1:0]          cfu_ram_adr,
    output logic [WB_DAT_W-1:0]          cfu_ram_dat_mosi,
    output logic [WB_SEL_W-1:0]          cfu_ram_sel,
    output logic                         cfu_ram_cyc,
    output logic                         cfu_ram_stb,
    output logic                         cfu_ram_we,
    output logic [2:0]                   cfu_ram_cti,
    output logic [1:0]                   cfu_ram_bte,
    input  logic [WB_DAT_W-1:0]          cfu_ram_dat_miso,
    input  logic                         cfu_ram_ack,
    input  logic                         cfu_ram_err,
    output logic [GRANT_W-1:0]           grant_id
);

    localparam logic [GRANT_W-1:0] GRANT_RST = GRANT_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_q, last_d;

    logic [GRANT_W-1:0] pick_win;
    logic               pick_vld;

    logic                sel_cyc, sel_stb, sel_we;
    logic [WB_ADR_W-1:0] sel_adr;
    logic [WB_DAT_W-1:0] sel_dat;
    logic [WB_SEL_W-1:0] sel_sel;

    logic       timeout_hit;
    logic       bus_en;
    logic       route_en;
    logic [1:0] resp;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_cyc),
        .last_i  (last_q),
        .win_o   (pick_win),
        .valid_o (pick_vld)
    );

    // Owner's request fields, selected by comparison so no index exceeds NUM_REQ.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        sel_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_cyc = req_cyc[i];
                sel_stb = req_stb[i];
                sel_we  = req_we[i];
                sel_adr = req_adr[WB_ADR_W*i +: WB_ADR_W];
                sel_dat = req_dat_mosi[WB_DAT_W*i +: WB_DAT_W];
                sel_sel = req_sel[WB_SEL_W*i +: WB_SEL_W];
            end
        end
    end

`ifdef CFU_RAM_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

    assign timeout_hit = (state_q == ARB_BUSY) && (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        to_cnt_d = '0;
        if ((state_q == ARB_BUSY) && !timeout_hit && sel_stb && !cfu_ram_ack && !cfu_ram_err) begin
            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_CNT_W'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_win;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (timeout_hit || !sel_cyc) begin
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= GRANT_RST;
            last_q  <= GRANT_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Reset gates the outputs directly so they drop in the same instant it rises.
    assign route_en = (state_q == ARB_BUSY) && !reset;
    assign bus_en   = route_en && !timeout_hit;
    assign resp     = resolve_ack_err(cfu_ram_ack, cfu_ram_err);

    assign cfu_ram_cyc      = bus_en & sel_cyc;
    assign cfu_ram_stb      = bus_en & sel_stb;
    assign cfu_ram_we       = bus_en & sel_we;
    assign cfu_ram_adr      = bus_en ? sel_adr : '0;
    assign cfu_ram_dat_mosi = bus_en ? sel_dat : '0;
    assign cfu_ram_sel      = bus_en ? sel_sel : '0;
    assign cfu_ram_cti      = 3'b000;
    assign cfu_ram_bte      = 2'b00;

    assign req_dat_miso = cfu_ram_dat_miso;
    assign grant_id     = grant_q;

    always_comb begin
        req_ack = '0;
        req_err = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (route_en && (grant_q == GRANT_W'(i))) begin
                req_ack[i] = resp[0] & ~timeout_hit;
                req_err[i] = resp[1] | timeout_hit;
            end
        end
    end

endmodule
